// File: rtl/la_pwr_pkg.sv
// Shared definitions for the power-gating sequencers (footer and header variants).
//   pwr_state_t     : 3-bit sequencer state encoding
//   PWR_DLY_DEF     : default clock cycles per switch stage
//   PWR_ISODLY_DEF  : default clock cycles between isolation change and switch step
//   pwr_max()       : elaboration helper for sizing the shared delay counter
package la_pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWRUP  = 3'd1,
        ST_ISOREL = 3'd2,
        ST_ON     = 3'd3,
        ST_ISOSET = 3'd4,
        ST_PWRDN  = 3'd5
    } pwr_state_t;

    localparam int PWR_DLY_DEF    = 8;
    localparam int PWR_ISODLY_DEF = 2;

    function automatic int pwr_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/la_footer_ctrl_timer.sv
// Down-counter used for both the per-stage delay and the isolation delay.
//   clk      : always-on clock
//   nreset   : asynchronous active-low reset (count cleared)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : start value; done is seen load_val+1 edges after the load edge
//   done     : terminal count reached (count == 0)
module la_footer_ctrl_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/la_footer_ctrl.sv
// Power-gating sequencer for a bank of N footer switches on one domain's vss.
// Power-up turns footers on one stage at a time, then releases isolation;
// power-down isolates first, then turns footers off in reverse order.
//   clk    : always-on clock
//   nreset : asynchronous active-low reset (all footers off, domain isolated)
//   req    : level request from the power manager, 1 = on (4-phase with ack)
//   ack    : 1 = power-up sequence completed; drops when power-down completes
//   nsleep : per-stage footer enable, thermometer coded, 0 = footer off
//   niso   : 0 = gated domain outputs clamped
//   busy   : 1 = a sequence is in progress
//
// state   | meaning
// OFF     | footers off, isolated, waiting for req=1
// PWRUP   | turning footers on, one stage per DLY cycles
// ISOREL  | all footers on, isolation released, settling ISODLY cycles
// ON      | domain on, ack=1, waiting for req=0
// ISOSET  | isolation asserted, settling ISODLY cycles
// PWRDN   | turning footers off in reverse order, one stage per DLY cycles
module la_footer_ctrl
    import la_pwr_pkg::*;
#(
    parameter int N      = 4,
    parameter int DLY    = PWR_DLY_DEF,
    parameter int ISODLY = PWR_ISODLY_DEF,
    parameter     PROP   = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         req,
    output logic         ack,
    output logic [N-1:0] nsleep,
    output logic         niso,
    output logic         busy
);

    localparam int TW = $clog2(pwr_max(DLY, ISODLY) + 1);
    localparam int IW = $clog2(N) + 1;

    // Timer reloads with delay-1 so the next step lands exactly delay edges later.
    localparam logic [TW-1:0] DLY_LD   = TW'(DLY - 1);
    localparam logic [TW-1:0] ISO_LD   = TW'(ISODLY - 1);
    localparam logic [IW-1:0] IDX_ALL  = IW'(N);
    localparam logic [IW-1:0] IDX_TOP  = IW'(N - 1);
    localparam logic [N-1:0]  NS_FIRST = N'(1);

    if (N < 1 || DLY < 1 || ISODLY < 1) begin : g_bad_param
        $error("la_footer_ctrl: N, DLY and ISODLY must all be >= 1");
    end
    if (PROP == "") begin : g_bad_prop
        $error("la_footer_ctrl: PROP must name a technology property");
    end

    pwr_state_t    state;
    logic [IW-1:0] idx;        // PWRUP: stages on; PWRDN: stages still on after this step
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    la_footer_ctrl_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .nreset   (nreset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = DLY_LD;
        case (state)
            ST_OFF: begin
                tmr_load = req;
            end
            ST_PWRUP: begin
                tmr_load = tmr_done;
                if (idx == IDX_ALL) begin
                    tmr_val = ISO_LD;
                end
            end
            ST_ON: begin
                tmr_load = !req;
                tmr_val  = ISO_LD;
            end
            ST_ISOSET: begin
                tmr_load = tmr_done;
            end
            ST_PWRDN: begin
                tmr_load = tmr_done && (idx != '0);
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= ST_OFF;
            idx    <= '0;
            nsleep <= '0;
            niso   <= 1'b0;
            ack    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (req) begin
                        state  <= ST_PWRUP;
                        nsleep <= NS_FIRST;
                        idx    <= IW'(1);
                        busy   <= 1'b1;
                    end
                end
                ST_PWRUP: begin
                    if (tmr_done) begin
                        if (idx == IDX_ALL) begin
                            state <= ST_ISOREL;
                            niso  <= 1'b1;
                        end else begin
                            nsleep <= (nsleep << 1) | NS_FIRST;
                            idx    <= idx + 1'b1;
                        end
                    end
                end
                ST_ISOREL: begin
                    if (tmr_done) begin
                        state <= ST_ON;
                        ack   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_ON: begin
                    if (!req) begin
                        state <= ST_ISOSET;
                        niso  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_ISOSET: begin
                    if (tmr_done) begin
                        state  <= ST_PWRDN;
                        nsleep <= nsleep >> 1;
                        idx    <= IDX_TOP;
                    end
                end
                ST_PWRDN: begin
                    if (tmr_done) begin
                        if (idx == '0) begin
                            state <= ST_OFF;
                            ack   <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            nsleep <= nsleep >> 1;
                            idx    <= idx - 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_OFF;
                    idx    <= '0;
                    nsleep <= '0;
                    niso   <= 1'b0;
                    ack    <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // ack stays high through power-down until the footers are all off, so it
    // may be seen in ISOSET/PWRDN, but it can only rise on entry to ON.
    logic [N-1:0] nsleep_inc;
    assign nsleep_inc = nsleep + 1'b1;

    a_iso_full: assert property (@(posedge clk) disable iff (!nreset)
        niso |-> (&nsleep));
    a_thermo: assert property (@(posedge clk) disable iff (!nreset)
        (nsleep & nsleep_inc) == '0);
    a_ack_state: assert property (@(posedge clk) disable iff (!nreset)
        ack |-> (state inside {ST_ON, ST_ISOSET, ST_PWRDN}));
    a_ack_rise: assert property (@(posedge clk) disable iff (!nreset)
        $rose(ack) |-> (state == ST_ON));

endmodule

// File: tb/tb_la_footer_ctrl.sv
module tb_la_footer_ctrl;

    typedef struct {
        string      nm;
        int         cyc;
        logic [3:0] ns;
        logic       iso;
        logic       ack;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic       nreset_a, req_a, niso_a, ack_a, busy_a;
    logic [3:0] ns_a;
    logic       nreset_b, req_b, niso_b, ack_b, busy_b;
    logic [0:0] ns_b;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [6:0] last_a = '0;
    logic [3:0] last_b = '0;

    la_footer_ctrl #(.N(4), .DLY(8), .ISODLY(2), .PROP("DEFAULT")) dut_a (
        .clk    (clk),
        .nreset (nreset_a),
        .req    (req_a),
        .ack    (ack_a),
        .nsleep (ns_a),
        .niso   (niso_a),
        .busy   (busy_a)
    );

    la_footer_ctrl #(.N(1), .DLY(1), .ISODLY(1), .PROP("DEFAULT")) dut_b (
        .clk    (clk),
        .nreset (nreset_b),
        .req    (req_b),
        .ack    (ack_b),
        .nsleep (ns_b),
        .niso   (niso_b),
        .busy   (busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string tag, input exp_t e, input int c,
                                  input logic [3:0] ns, input logic i,
                                  input logic a, input logic b);
        n_tests++;
        if (c !== e.cyc || ns !== e.ns || i !== e.iso || a !== e.ack || b !== e.busy) begin
            n_fail++;
            $display("FAIL %s/%s: got cyc=%0d nsleep=%b niso=%b ack=%b busy=%b, expected cyc=%0d nsleep=%b niso=%b ack=%b busy=%b",
                     tag, e.nm, c, ns, i, a, b, e.cyc, e.ns, e.iso, e.ack, e.busy);
        end
    endfunction

    function automatic void pa(input string nm, input int c, input logic [3:0] ns,
                               input logic i, input logic a, input logic b);
        exp_t e;
        e = '{nm, c, ns, i, a, b};
        qa.push_back(e);
    endfunction

    function automatic void pb(input string nm, input int c, input logic ns,
                               input logic i, input logic a, input logic b);
        exp_t e;
        e = '{nm, c, {3'b000, ns}, i, a, b};
        qb.push_back(e);
    endfunction

    function automatic void push_up_a(input int t);
        pa("pu_s0",   t,      4'b0001, 1'b0, 1'b0, 1'b1);
        pa("pu_s1",   t + 8,  4'b0011, 1'b0, 1'b0, 1'b1);
        pa("pu_s2",   t + 16, 4'b0111, 1'b0, 1'b0, 1'b1);
        pa("pu_s3",   t + 24, 4'b1111, 1'b0, 1'b0, 1'b1);
        pa("pu_niso", t + 32, 4'b1111, 1'b1, 1'b0, 1'b1);
        pa("pu_ack",  t + 34, 4'b1111, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic void push_dn_a(input int t);
        pa("pd_iso", t,      4'b1111, 1'b0, 1'b1, 1'b1);
        pa("pd_s3",  t + 2,  4'b0111, 1'b0, 1'b1, 1'b1);
        pa("pd_s2",  t + 10, 4'b0011, 1'b0, 1'b1, 1'b1);
        pa("pd_s1",  t + 18, 4'b0001, 1'b0, 1'b1, 1'b1);
        pa("pd_s0",  t + 26, 4'b0000, 1'b0, 1'b1, 1'b1);
        pa("pd_ack", t + 34, 4'b0000, 1'b0, 1'b0, 1'b0);
    endfunction

    // Monitors: every change of the observed outputs consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if ({ns_a, niso_a, ack_a, busy_a} !== last_a) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut_a_unexpected: got cyc=%0d nsleep=%b niso=%b ack=%b busy=%b, expected no change",
                         cyc, ns_a, niso_a, ack_a, busy_a);
            end else begin
                e = qa.pop_front();
                check("dut_a", e, cyc, ns_a, niso_a, ack_a, busy_a);
            end
            last_a = {ns_a, niso_a, ack_a, busy_a};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if ({ns_b, niso_b, ack_b, busy_b} !== last_b) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut_b_unexpected: got cyc=%0d nsleep=%b niso=%b ack=%b busy=%b, expected no change",
                         cyc, ns_b, niso_b, ack_b, busy_b);
            end else begin
                e = qb.pop_front();
                check("dut_b", e, cyc, {3'b000, ns_b}, niso_b, ack_b, busy_b);
            end
            last_b = {ns_b, niso_b, ack_b, busy_b};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic direct_a(input string nm);
        n_tests++;
        if ({ns_a, niso_a, ack_a, busy_a} !== 7'b0) begin
            n_fail++;
            $display("FAIL %s: got nsleep=%b niso=%b ack=%b busy=%b, expected all 0",
                     nm, ns_a, niso_a, ack_a, busy_a);
        end
    endtask

    task automatic seq_a();
        int t;
        tick(3);
        direct_a("reset_a");
        req_a = 1'b0;
        nreset_a = 1'b1;
        tick(3);
        // plain power-up, then req held high (no activity)
        req_a = 1'b1;
        t = cyc + 1;
        push_up_a(t);
        tick(40);
        // plain power-down, then req held low
        req_a = 1'b0;
        t = cyc + 1;
        push_dn_a(t);
        tick(40);
        // req drops at t5 of power-up: ignored, power-down starts at t35
        req_a = 1'b1;
        t = cyc + 1;
        push_up_a(t);
        tick(5);
        req_a = 1'b0;
        push_dn_a(t + 35);
        tick(75);
        // async reset at t12 of power-up, then restart from stage 0
        req_a = 1'b1;
        t = cyc + 1;
        pa("rst_s0", t,      4'b0001, 1'b0, 1'b0, 1'b1);
        pa("rst_s1", t + 8,  4'b0011, 1'b0, 1'b0, 1'b1);
        pa("rst_clr", t + 12, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick(12);
        @(posedge clk);
        #1 nreset_a = 1'b0;
        #1 direct_a("reset_async_a");
        tick(2);
        nreset_a = 1'b1;
        t = cyc + 1;
        push_up_a(t);
        tick(40);
        req_a = 1'b0;
        t = cyc + 1;
        push_dn_a(t);
        tick(40);
    endtask

    task automatic seq_b();
        int t;
        tick(3);
        n_tests++;
        if ({ns_b, niso_b, ack_b, busy_b} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_b: got nsleep=%b niso=%b ack=%b busy=%b, expected all 0",
                     ns_b, niso_b, ack_b, busy_b);
        end
        req_b = 1'b0;
        nreset_b = 1'b1;
        tick(3);
        req_b = 1'b1;
        t = cyc + 1;
        pb("c_pu_s0",   t,     1'b1, 1'b0, 1'b0, 1'b1);
        pb("c_pu_niso", t + 1, 1'b1, 1'b1, 1'b0, 1'b1);
        pb("c_pu_ack",  t + 2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(6);
        req_b = 1'b0;
        t = cyc + 1;
        pb("c_pd_iso", t,     1'b1, 1'b0, 1'b1, 1'b1);
        pb("c_pd_s0",  t + 1, 1'b0, 1'b0, 1'b1, 1'b1);
        pb("c_pd_ack", t + 2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(6);
        // req drops during power-up: ON for one cycle, then power-down
        req_b = 1'b1;
        t = cyc + 1;
        pb("r_pu_s0",   t,     1'b1, 1'b0, 1'b0, 1'b1);
        pb("r_pu_niso", t + 1, 1'b1, 1'b1, 1'b0, 1'b1);
        pb("r_pu_ack",  t + 2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        req_b = 1'b0;
        pb("r_pd_iso", t + 3, 1'b1, 1'b0, 1'b1, 1'b1);
        pb("r_pd_s0",  t + 4, 1'b0, 1'b0, 1'b1, 1'b1);
        pb("r_pd_ack", t + 5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(10);
    endtask

    initial begin
        nreset_a = 1'b0;
        req_a    = 1'b1;
        nreset_b = 1'b0;
        req_b    = 1'b1;
        fork
            seq_a();
            seq_b();
        join
        tick(3);
        n_tests++;
        if (qa.size() != 0) begin
            n_fail++;
            $display("FAIL dut_a_pending: got %0d unmatched expected events, expected 0", qa.size());
        end
        n_tests++;
        if (qb.size() != 0) begin
            n_fail++;
            $display("FAIL dut_b_pending: got %0d unmatched expected events, expected 0", qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
